// File: rtl/fifo_pkg.sv
// Shared types and level-flag constants for the FIFO occupancy controller.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  // Default thresholds: almost-full sits this many entries below DEPTH.
  localparam int AF_MARGIN    = 2;
  localparam int AE_LEVEL_DEF = 2;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping storage-array pointer; clr has priority over inc.
module fifo_ptr #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_inc,
  input  logic                  i_clr,
  output logic [ADDR_WIDTH-1:0] o_ptr
);

  logic [ADDR_WIDTH-1:0] r_ptr;

  // Natural overflow of the ADDR_WIDTH-bit register provides the modulo-DEPTH wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_ptr <= '0;
    else if (i_clr)
      r_ptr <= '0;
    else if (i_inc)
      r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_level_ctrl.sv
// FIFO pointer/occupancy controller with registered level flags and sticky errors.
// Optional high-water mark tracking is enabled by defining FIFO_LEVEL_CTRL_PEAK_EN.
module fifo_level_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - AF_MARGIN,
  parameter int AE_LEVEL   = AE_LEVEL_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic                  i_wr,
  input  logic                  i_rd,
  input  logic                  i_clr_err,
  output logic [ADDR_WIDTH-1:0] o_w_addr,
  output logic [ADDR_WIDTH-1:0] o_r_addr,
  output logic                  o_w_en,
  output logic                  o_r_en,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_empty,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic [ADDR_WIDTH:0]   o_peak
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] AF_THR  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_THR  = CW'(AE_LEVEL);

  fifo_state_t   r_state;
  fifo_state_t   w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_empty;
  logic          r_full;
  logic          r_almost_empty;
  logic          r_almost_full;
  logic          r_overflow;
  logic          r_underflow;
  logic          w_w_en;
  logic          w_r_en;
  logic          w_ovf_set;
  logic          w_unf_set;

  assign w_w_en = i_wr & ~i_flush & ((r_state != FULL) | i_rd);
  assign w_r_en = i_rd & ~i_flush & (r_state != EMPTY);

  assign w_ovf_set = i_wr & ~w_w_en & ~i_flush;
  assign w_unf_set = i_rd & ~w_r_en & ~i_flush;

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush)
      w_count_nxt = '0;
    else
      w_count_nxt = r_count + CW'(w_w_en) - CW'(w_r_en);
  end

  always_comb begin
    w_state_nxt = PARTIAL;
    if (w_count_nxt == '0)
      w_state_nxt = EMPTY;
    else if (w_count_nxt == DEPTH_C)
      w_state_nxt = FULL;
  end

  // Flags are derived from the next count so they update on the same edge as o_count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= EMPTY;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_count        <= w_count_nxt;
      r_empty        <= (w_state_nxt == EMPTY);
      r_full         <= (w_state_nxt == FULL);
      r_almost_empty <= (w_count_nxt <= AE_THR);
      r_almost_full  <= (w_count_nxt >= AF_THR);
    end
  end

  // A set event in the same cycle as a clear wins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)
        r_overflow <= 1'b1;
      else if (i_clr_err)
        r_overflow <= 1'b0;
      if (w_unf_set)
        r_underflow <= 1'b1;
      else if (i_clr_err)
        r_underflow <= 1'b0;
    end
  end

`ifdef FIFO_LEVEL_CTRL_PEAK_EN
  logic [CW-1:0] r_peak;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_peak <= '0;
    else if (i_clr_err)
      r_peak <= '0;
    else if (w_count_nxt > r_peak)
      r_peak <= w_count_nxt;
  end

  assign o_peak = r_peak;
`else
  assign o_peak = '0;
`endif

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_w_en),
    .i_clr   (i_flush),
    .o_ptr   (o_w_addr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_r_en),
    .i_clr   (i_flush),
    .o_ptr   (o_r_addr)
  );

  assign o_w_en         = w_w_en;
  assign o_r_en         = w_r_en;
  assign o_count        = r_count;
  assign o_empty        = r_empty;
  assign o_full         = r_full;
  assign o_almost_empty = r_almost_empty;
  assign o_almost_full  = r_almost_full;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_level_ctrl.sv
// Directed self-checking bench for fifo_level_ctrl at ADDR_WIDTH=2 (DEPTH=4).
module tb_fifo_level_ctrl;

  localparam int AW = 2;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_flush;
  logic          i_wr;
  logic          i_rd;
  logic          i_clr_err;
  logic [AW-1:0] o_w_addr;
  logic [AW-1:0] o_r_addr;
  logic          o_w_en;
  logic          o_r_en;
  logic [AW:0]   o_count;
  logic          o_empty;
  logic          o_full;
  logic          o_almost_empty;
  logic          o_almost_full;
  logic          o_overflow;
  logic          o_underflow;
  logic [AW:0]   o_peak;

  int checks   = 0;
  int failures = 0;
  int peak_exp;

  fifo_level_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(3), .AE_LEVEL(2)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_flush        (i_flush),
    .i_wr           (i_wr),
    .i_rd           (i_rd),
    .i_clr_err      (i_clr_err),
    .o_w_addr       (o_w_addr),
    .o_r_addr       (o_r_addr),
    .o_w_en         (o_w_en),
    .o_r_en         (o_r_en),
    .o_count        (o_count),
    .o_empty        (o_empty),
    .o_full         (o_full),
    .o_almost_empty (o_almost_empty),
    .o_almost_full  (o_almost_full),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow),
    .o_peak         (o_peak)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_flush = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_clr_err = 1'b0;
    #2;
    chk("rst_count", 32'(o_count), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_ae", 32'(o_almost_empty), 1);
    chk("rst_af", 32'(o_almost_full), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    chk("rst_unf", 32'(o_underflow), 0);
    chk("rst_peak", 32'(o_peak), 0);
    chk("rst_waddr", 32'(o_w_addr), 0);
    tick();
    i_reset = 1'b0;

    // Fill from empty: af asserts at count 3, full at 4, write pointer wraps to 0.
    for (int k = 1; k <= 4; k++) begin
      i_wr = 1'b1;
      #1;
      chk("fill_wen", 32'(o_w_en), 1);
      tick();
      chk("fill_count", 32'(o_count), 32'(k));
      chk("fill_af", 32'(o_almost_full), (k >= 3) ? 1 : 0);
      chk("fill_ae", 32'(o_almost_empty), (k <= 2) ? 1 : 0);
      chk("fill_full", 32'(o_full), (k == 4) ? 1 : 0);
    end
    chk("fill_waddr_wrap", 32'(o_w_addr), 0);
    chk("fill_empty", 32'(o_empty), 0);

    // Write while full: rejected, overflow sticks until cleared.
    #1;
    chk("ovf_wen", 32'(o_w_en), 0);
    tick();
    chk("ovf_flag", 32'(o_overflow), 1);
    chk("ovf_count", 32'(o_count), 4);
    i_wr = 1'b0; i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk("ovf_clr", 32'(o_overflow), 0);

    // Simultaneous read and write while full.
    i_wr = 1'b1; i_rd = 1'b1;
    #1;
    chk("full_rw_wen", 32'(o_w_en), 1);
    chk("full_rw_ren", 32'(o_r_en), 1);
    tick();
    chk("full_rw_count", 32'(o_count), 4);
    chk("full_rw_full", 32'(o_full), 1);
    chk("full_rw_waddr", 32'(o_w_addr), 1);
    chk("full_rw_raddr", 32'(o_r_addr), 1);

    // Drop to 3 then flush with a concurrent write.
    i_wr = 1'b0; i_rd = 1'b1;
    tick();
    chk("rd_count", 32'(o_count), 3);
    chk("rd_full", 32'(o_full), 0);
    chk("rd_raddr", 32'(o_r_addr), 2);
    i_rd = 1'b0; i_wr = 1'b1; i_flush = 1'b1;
    #1;
    chk("flush_wen", 32'(o_w_en), 0);
    tick();
    i_flush = 1'b0; i_wr = 1'b0;
    chk("flush_count", 32'(o_count), 0);
    chk("flush_empty", 32'(o_empty), 1);
    chk("flush_waddr", 32'(o_w_addr), 0);
    chk("flush_raddr", 32'(o_r_addr), 0);
    chk("flush_no_ovf", 32'(o_overflow), 0);
`ifdef FIFO_LEVEL_CTRL_PEAK_EN
    peak_exp = 4;
`else
    peak_exp = 0;
`endif
    chk("flush_peak", 32'(o_peak), 32'(peak_exp));

    // Simultaneous read and write while empty: only the write goes through.
    i_wr = 1'b1; i_rd = 1'b1;
    #1;
    chk("empty_rw_wen", 32'(o_w_en), 1);
    chk("empty_rw_ren", 32'(o_r_en), 0);
    tick();
    i_rd = 1'b0;
    chk("empty_rw_count", 32'(o_count), 1);
    chk("empty_rw_unf", 32'(o_underflow), 1);
    chk("empty_rw_waddr", 32'(o_w_addr), 1);

    // Burst then asynchronous reset between edges.
    tick();
    tick();
    chk("burst_count", 32'(o_count), 3);
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_count", 32'(o_count), 0);
    chk("arst_waddr", 32'(o_w_addr), 0);
    chk("arst_empty", 32'(o_empty), 1);
    chk("arst_unf", 32'(o_underflow), 0);
    #1;
    i_reset = 1'b0;
    #1;
    chk("post_rst_wen", 32'(o_w_en), 1);
    chk("post_rst_waddr", 32'(o_w_addr), 0);
    tick();
    i_wr = 1'b0;
    chk("post_rst_count", 32'(o_count), 1);
    chk("post_rst_waddr_inc", 32'(o_w_addr), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
